// File: rtl/sms_power_engine.sv
// sms_power_engine: per-lane GF(2^6) exponentiation p = x^e (poly x^6+x+1),
// computed MSB-first by square-and-multiply over exactly six COMPUTE cycles.
// All lanes share one FSM and one exponent.
// Optional build macro SMS_LINEAR_TERM_EN: each lane result is additionally
// XORed with the parity of (captured x & LIN_MASK) replicated over 6 bits.
module sms_power_engine #(
  parameter int unsigned LANES    = 4,
  parameter logic [5:0]  LIN_MASK = 6'h14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6*LANES-1:0] in_x,
  input  logic [5:0]         in_e,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6*LANES-1:0] out_y,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t             state;
  logic [6*LANES-1:0] x_q;
  logic [6*LANES-1:0] acc_q;
  logic [6*LANES-1:0] acc_d;
  logic [6*LANES-1:0] y_d;
  logic [5:0]         e_q;
  logic [2:0]         cnt_q;

  // GF(2^6) multiply; x^6 folds back to x+1 (6'h03).
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] t;
    r = 6'h00;
    t = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[4:0], 1'b0} ^ (t[5] ? 6'h03 : 6'h00);
    end
    return r;
  endfunction

  // One square-and-multiply step per lane, plus the final output mapping.
  always_comb begin
    logic [5:0] sq;
    acc_d = '0;
    y_d   = '0;
    sq    = 6'h00;
    for (int i = 0; i < int'(LANES); i++) begin
      sq = gf_mul(acc_q[6*i +: 6], acc_q[6*i +: 6]);
      acc_d[6*i +: 6] = e_q[cnt_q] ? gf_mul(sq, x_q[6*i +: 6]) : sq;
`ifdef SMS_LINEAR_TERM_EN
      y_d[6*i +: 6] = acc_d[6*i +: 6] ^ {6{^(x_q[6*i +: 6] & LIN_MASK)}};
`else
      y_d[6*i +: 6] = acc_d[6*i +: 6];
`endif
    end
  end

`ifndef SMS_LINEAR_TERM_EN
  // LIN_MASK only matters when the linear term is built in.
  logic [5:0] unused_lin_mask;
  assign unused_lin_mask = LIN_MASK;
`endif

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      e_q       <= 6'h00;
      acc_q     <= '0;
      cnt_q     <= 3'd5;
      out_y     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= in_x;
            e_q      <= in_e;
            acc_q    <= {LANES{6'h01}};
            cnt_q    <= 3'd5;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc_q <= acc_d;
          if (cnt_q == 3'd0) begin
            cnt_q     <= 3'd5;
            out_y     <= y_d;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sms_power_engine.sv
// Bench for sms_power_engine (default build, LANES=4, linear term off).
module tb_sms_power_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_x;
  logic [5:0]  in_e;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_y;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sms_power_engine #(.LANES(4), .LIN_MASK(6'h14)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_e     (in_e),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference: carry-less product then polynomial long division by x^6+x+1.
  function automatic logic [5:0] m_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = 11'h000;
    for (int i = 0; i < 6; i++)
      if (b[i]) p = p ^ ({5'b0, a} << i);
    for (int k = 10; k >= 6; k--)
      if (p[k]) p = p ^ (11'h043 << (k - 6));
    return p[5:0];
  endfunction

  // x^e as e repeated multiplications starting from 1.
  function automatic logic [5:0] m_pow(input logic [5:0] x, input logic [5:0] e);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < int'(e); i++) r = m_mul(r, x);
    return r;
  endfunction

  function automatic logic [23:0] m_lanes(input logic [23:0] x, input logic [5:0] e);
    logic [23:0] y;
    y = '0;
    for (int l = 0; l < 4; l++) y[6*l +: 6] = m_pow(x[6*l +: 6], e);
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One transaction from IDLE; out_ready withheld for 'hold' DONE cycles.
  task automatic run_op(input logic [23:0] x, input logic [5:0] e, input int hold,
                        output logic [23:0] y);
    int n;
    logic [23:0] y0;
    @(negedge clk);
    check("ready_idle", {31'b0, in_ready}, 1);
    in_valid = 1'b1;
    in_x     = x;
    in_e     = e;
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = 24'($urandom);
    in_e     = 6'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      if (n == 2) check("busy_compute", {30'b0, in_ready, busy}, 2'b01);
      @(negedge clk);
      n++;
      in_x     = 24'($urandom);
      in_e     = 6'($urandom);
      in_valid = 1'($urandom);
    end
    check("latency", n, 6);
    y  = out_y;
    y0 = out_y;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_hold", {6'b0, out_valid, in_ready, out_y}, {6'b0, 1'b1, 1'b0, y0});
      in_valid = 1'b1;
      in_x     = 24'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after_hs", {29'b0, out_valid, in_ready, busy}, 3'b010);
  endtask

  typedef struct {
    logic [23:0] x;
    logic [5:0]  e;
    logic [23:0] y;
  } vec_t;

  initial begin
    vec_t        vt[8];
    logic [23:0] y;
    logic [23:0] x;
    logic [5:0]  e;
    int          n;
    int          ov_seen;
    int          first;
    int          second;

    vt[0] = '{{6'h3F, 6'h2A, 6'h01, 6'h00}, 6'd1,  {6'h3F, 6'h2A, 6'h01, 6'h00}};
    vt[1] = '{{6'h00, 6'h00, 6'h00, 6'h00}, 6'd0,  {6'h01, 6'h01, 6'h01, 6'h01}};
    vt[2] = '{{6'h02, 6'h15, 6'h3F, 6'h00}, 6'd63, {6'h01, 6'h01, 6'h01, 6'h00}};
    vt[3] = '{{6'h02, 6'h02, 6'h02, 6'h02}, 6'd6,  {6'h03, 6'h03, 6'h03, 6'h03}};
    vt[4] = '{{6'h00, 6'h00, 6'h00, 6'h00}, 6'd41, {6'h00, 6'h00, 6'h00, 6'h00}};
    vt[5] = '{{6'h02, 6'h01, 6'h02, 6'h01}, 6'd5,  {6'h20, 6'h01, 6'h20, 6'h01}};
    vt[6] = '{{6'h02, 6'h00, 6'h01, 6'h02}, 6'd7,  {6'h06, 6'h00, 6'h01, 6'h06}};
    vt[7] = '{{6'h01, 6'h3F, 6'h00, 6'h02}, 6'd0,  {6'h01, 6'h01, 6'h01, 6'h01}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_e      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {5'b0, in_ready, out_valid, busy, out_y}, {5'b0, 3'b100, 24'h0});
    rst = 1'b0;

    // Directed table; vector 0 also holds out_ready low for 10 DONE cycles.
    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].x, vt[i].e, (i == 0) ? 10 : i % 3, y);
      check($sformatf("table_%0d", i), {8'b0, y}, {8'b0, vt[i].y});
    end

    // Exhaustive 64x64 (x,e): four x values per transaction.
    for (int ei = 0; ei < 64; ei++) begin
      for (int xb = 0; xb < 16; xb++) begin
        x = {6'(xb * 4 + 3), 6'(xb * 4 + 2), 6'(xb * 4 + 1), 6'(xb * 4)};
        e = 6'(ei);
        run_op(x, e, 0, y);
        if (y !== m_lanes(x, e))
          check($sformatf("exh_e%0d_xb%0d", ei, xb), {8'b0, y}, {8'b0, m_lanes(x, e)});
      end
    end
    check("exh_done", {8'b0, y}, {8'b0, m_lanes(x, e)});

    // Randomized operands and randomized consumer delay.
    for (int i = 0; i < 150; i++) begin
      x = 24'($urandom);
      e = 6'($urandom);
      run_op(x, e, int'($urandom_range(0, 3)), y);
      check("rand_op", {8'b0, y}, {8'b0, m_lanes(x, e)});
    end

    // out_ready held high throughout, in_valid held high: one result per 8 cycles.
    x = 24'h8A3_1C5;
    e = 6'd45;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = x;
    in_e      = e;
    first  = -1;
    second = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) begin
          first = i;
          check("b2b_y", {8'b0, out_y}, {8'b0, m_lanes(x, e)});
        end else if (second < 0) begin
          second = i;
        end
      end
    end
    check("b2b_first", first, 7);
    check("b2b_gap", second - first, 8);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;

    // Reset during COMPUTE discards the operation.
    @(negedge clk);
    check("ready_pre_rst", {31'b0, in_ready}, 1);
    in_valid = 1'b1;
    in_x     = 24'hFFF_FFF;
    in_e     = 6'd13;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_compute", {6'b0, out_valid, busy, out_y}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("ready_after_rst", {31'b0, in_ready}, 1);
    ov_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("no_ov_after_rst_c", ov_seen, 0);

    // Reset during DONE discards the pending result.
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 24'h123_456;
    in_e     = 6'd9;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency_pre_rst", n, 6);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_done", {6'b0, out_valid, busy, out_y}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("ready_after_rst_d", {31'b0, in_ready}, 1);
    ov_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("no_ov_after_rst_d", ov_seen, 0);

    // Engine still works after reset.
    x = 24'h0C3_2B1;
    e = 6'd22;
    run_op(x, e, 1, y);
    check("post_rst_op", {8'b0, y}, {8'b0, m_lanes(x, e)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
